// File: rtl/apb_pack.sv
// Shared types and default parameters for the APB initiator and its helpers.
package apb_pack;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the cycle in which the wait limit is hit.
// A TIMEOUT of 0 disables expiry entirely.
module apb_wait_timer
  import apb_pack::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int          CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(TIMEOUT);

  logic [CW-1:0] count;
  logic [CW:0]   count_next;

  // One extra bit so the comparison against LIMIT never wraps.
  assign count_next = {1'b0, count} + (CW + 1)'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order in which always blocks run.
  always_ff @(posedge pclk) begin
    if (!presetn || clear) begin
      count <= '0;
    end else if (inc && (count_next <= LIMIT)) begin
      count <= count_next[CW-1:0];
    end
  end

  // Expiry fires on the wait cycle that would bring the count to TIMEOUT, so
  // the transfer leaves ACCESS after exactly TIMEOUT unanswered cycles.
  assign expired = (TIMEOUT > 0) && inc && (count_next >= LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB initiator: accepts one command at a time on a valid/ready port, runs the
// IDLE -> SETUP -> ACCESS sequence and returns a one-cycle response pulse.
module apb_master
  import apb_pack::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  apb_state_e state;
  logic       wait_inc;
  logic       wait_clear;
  logic       expired;
  logic       done;

  assign cmd_ready  = (state == APB_IDLE) && presetn;
  assign wait_inc   = (state == APB_ACCESS) && !pready;
  assign done       = (state == APB_ACCESS) && (pready || expired);
  assign wait_clear = (state != APB_ACCESS) || done;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk    (pclk),
    .presetn (presetn),
    .clear   (wait_clear),
    .inc     (wait_inc),
    .expired (expired)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked branch and only
  // takes effect on a pclk edge; the datapath registers are cleared with it.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state      <= APB_IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        APB_IDLE: begin
          if (cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            psel   <= 1'b1;
            state  <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          penable <= 1'b1;
          state   <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (done) begin
            // A real slave answer wins; otherwise this is a timeout completion.
            psel       <= 1'b0;
            penable    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_slverr <= pready ? pslverr : 1'b1;
            rsp_rdata  <= (pready && !pwrite) ? prdata : '0;
            state      <= APB_IDLE;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= APB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed and randomized bench for apb_master with a transaction-level model
// and an emulated slave that inserts a chosen number of wait states.
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  int errors = 0;
  int checks = 0;

  apb_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_cycle();
    cmd_valid = 1'b0;
    tick();
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_psel", psel, 1'b0);
  endtask

  // One complete transfer, entered and left with the DUT in the cycle where
  // cmd_ready is expected high. waits = pready-low ACCESS cycles before the
  // slave answers; hold keeps cmd_valid high with junk payload meanwhile.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int waits, input logic err, input logic [DW-1:0] rd,
                         input bit hold, input string tag);
    int            exp_acc;
    int            n_acc;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;

    if (TO > 0 && waits >= TO) begin
      exp_acc   = TO;
      exp_err   = 1'b1;
      exp_rdata = '0;
    end else begin
      exp_acc   = waits + 1;
      exp_err   = err;
      exp_rdata = wr ? '0 : rd;
    end

    check({tag, "_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    pready    = 1'b0;
    tick();

    if (hold) begin
      cmd_write = ~wr;
      cmd_addr  = ~addr;
      cmd_wdata = ~wd;
    end else begin
      cmd_valid = 1'b0;
    end
    check({tag, "_setup_psel"}, psel, 1'b1);
    check({tag, "_setup_pen"}, penable, 1'b0);
    check({tag, "_setup_addr"}, paddr, addr);
    check({tag, "_setup_wr"}, pwrite, wr);
    check({tag, "_setup_wdata"}, pwdata, wd);
    check({tag, "_setup_ready"}, cmd_ready, 1'b0);
    check({tag, "_setup_rsp"}, rsp_valid, 1'b0);
    tick();

    n_acc = 0;
    while (!rsp_valid && n_acc < 40) begin
      check({tag, "_acc_psel"}, psel, 1'b1);
      check({tag, "_acc_pen"}, penable, 1'b1);
      check({tag, "_acc_addr"}, paddr, addr);
      check({tag, "_acc_wdata"}, pwdata, wd);
      check({tag, "_acc_wr"}, pwrite, wr);
      pready  = (n_acc == waits);
      pslverr = pready ? err : 1'($urandom);
      prdata  = pready ? rd : $urandom;
      n_acc++;
      tick();
    end
    pready  = 1'b0;
    pslverr = 1'($urandom);
    prdata  = $urandom;

    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_access_cycles"}, 64'(n_acc), 64'(exp_acc));
    check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_rsp_slverr"}, rsp_slverr, exp_err);
    check({tag, "_rsp_psel"}, psel, 1'b0);
    check({tag, "_rsp_pen"}, penable, 1'b0);
  endtask

  initial begin
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, '0);
    check("rst_pwdata", pwdata, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_rsp_slverr", rsp_slverr, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    presetn = 1'b1;
    #1;
    check("rst_release_ready", cmd_ready, 1'b1);

    // Write, zero wait states
    do_xfer(1'b1, 8'h10, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_AAAA, 1'b0, "wr0");
    idle_cycle();

    // Read with three wait states
    do_xfer(1'b0, 8'h10, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, "rd3");
    idle_cycle();

    // Slave error, next command accepted straight from the response cycle
    do_xfer(1'b0, 8'hFF, 32'h0, 0, 1'b1, 32'h1234_5678, 1'b0, "slverr");
    do_xfer(1'b1, 8'h01, 32'hCAFE_F00D, 1, 1'b0, 32'h0, 1'b0, "after_err");
    idle_cycle();

    // Timeout, then a late pready must be ignored
    do_xfer(1'b0, 8'h33, 32'h0, 1000, 1'b0, 32'hFFFF_FFFF, 1'b0, "timeout");
    cmd_valid = 1'b0;
    pready    = 1'b1;
    prdata    = 32'hBAD0_BAD0;
    pslverr   = 1'b1;
    tick();
    check("late_pready_rsp", rsp_valid, 1'b0);
    check("late_pready_psel", psel, 1'b0);
    tick();
    check("late_pready_rsp2", rsp_valid, 1'b0);
    check("late_pready_ready", cmd_ready, 1'b1);
    pready  = 1'b0;
    pslverr = 1'b0;

    // Reset while waiting in ACCESS
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h20;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_rst_in_wait", penable, 1'b1);
    presetn = 1'b0;
    tick();
    check("mid_rst_psel", psel, 1'b0);
    check("mid_rst_penable", penable, 1'b0);
    check("mid_rst_rsp", rsp_valid, 1'b0);
    check("mid_rst_ready_low", cmd_ready, 1'b0);
    tick();
    presetn = 1'b1;
    #1;
    check("mid_rst_ready", cmd_ready, 1'b1);
    check("mid_rst_paddr", paddr, '0);
    tick();
    check("mid_rst_no_rsp", rsp_valid, 1'b0);
    do_xfer(1'b0, 8'h21, 32'h0, 3, 1'b0, 32'h0BAD_CAFE, 1'b0, "post_rst");
    idle_cycle();

    // Back-to-back with cmd_valid held throughout
    do_xfer(1'b1, 8'h00, 32'h1111_0000, 0, 1'b0, 32'h0, 1'b1, "b2b0");
    do_xfer(1'b1, 8'h04, 32'h2222_0004, 0, 1'b0, 32'h0, 1'b1, "b2b1");
    do_xfer(1'b1, 8'h08, 32'h3333_0008, 0, 1'b0, 32'h0, 1'b0, "b2b2");
    idle_cycle();

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      logic          r_wr;
      logic [AW-1:0] r_addr;
      logic [DW-1:0] r_wd;
      logic [DW-1:0] r_rd;
      logic          r_err;
      int            r_waits;
      bit            r_hold;
      r_wr    = 1'($urandom);
      r_addr  = AW'($urandom);
      r_wd    = $urandom;
      r_rd    = $urandom;
      r_err   = ($urandom_range(0, 3) == 0);
      r_waits = $urandom_range(0, 6);
      r_hold  = 1'($urandom);
      do_xfer(r_wr, r_addr, r_wd, r_waits, r_err, r_rd, r_hold, "rand");
      if (!r_hold) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
